mm_stream_src: RTL and testbench

MM_STREAM_SRC -- requirements
Module: mm_stream_src

---
 rtl/mm_stream_pkg.sv | 7 +
 rtl/mm_sdp_ram.sv | 18 +
 rtl/mm_stream_src.sv | 137 +++++++++++++
 tb/tb_mm_stream_src.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/mm_stream_pkg.sv
// mm_stream_pkg: shared FSM type, stream width and default job sizes for mm_stream_src.
package mm_stream_pkg;
    localparam int AXIS_W        = 32;
    localparam int DEF_IN_WORDS  = 128;
    localparam int DEF_OUT_WORDS = 128;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/mm_sdp_ram.sv
// mm_sdp_ram: simple dual-port RAM, one write port and one registered read port.
module mm_sdp_ram #(
    parameter int DEPTH = 128,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [WIDTH-1:0]         rdata_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
        rdata_o <= mem_q[raddr_i];
    end
endmodule

// File: rtl/mm_stream_src.sv
// mm_stream_src: streams the operand buffer out on x_*, captures y_* into the result buffer.
// Define MM_SRC_TLAST_CHECK_EN to flag misplaced y_TLAST on err.
module mm_stream_src
    import mm_stream_pkg::*;
#(
    parameter int IN_WORDS  = DEF_IN_WORDS,
    parameter int OUT_WORDS = DEF_OUT_WORDS
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         ld_en,
    input  logic [$clog2(IN_WORDS)-1:0]  ld_addr,
    input  logic [AXIS_W-1:0]            ld_data,
    input  logic [$clog2(OUT_WORDS)-1:0] rd_addr,
    output logic [AXIS_W-1:0]            rd_data,
    input  logic                         start,
    output logic                         busy,
    output logic                         done,
    output logic                         err,
    output logic [AXIS_W-1:0]            x_TDATA,
    output logic                         x_TVALID,
    input  logic                         x_TREADY,
    output logic                         x_TLAST,
    input  logic [AXIS_W-1:0]            y_TDATA,
    input  logic                         y_TVALID,
    output logic                         y_TREADY,
    input  logic                         y_TLAST
);
    localparam int IAW = $clog2(IN_WORDS);
    localparam int OAW = $clog2(OUT_WORDS);
    localparam int ICW = IAW + 1;
    localparam int OCW = OAW + 1;
    localparam logic [ICW-1:0] IN_N  = ICW'(IN_WORDS);
    localparam logic [OCW-1:0] OUT_N = OCW'(OUT_WORDS);

    state_t            state_q;
    logic [ICW-1:0]    tx_cnt_q, fetch_q;
    logic [OCW-1:0]    rx_cnt_q;
    logic              rv_q, xv_q, sv_q, err_q;
    logic [AXIS_W-1:0] xd_q, sd_q, op_rd;
    logic              run, x_fire, y_fire, out_load, issue, to_skid, tl_bad;
    logic              xv_d, sv_d;
    logic [AXIS_W-1:0] xd_d, sd_d;
    logic [1:0]        occ;

    assign run      = state_q == RUN;
    assign x_fire   = xv_q & x_TREADY;
    assign y_TREADY = run & (rx_cnt_q != OUT_N);
    assign y_fire   = y_TREADY & y_TVALID;
    assign out_load = ~xv_q | x_fire;
    // A read is issued only if output+skid can absorb it even if x stalls next cycle.
    assign occ      = {1'b0, xv_q} + {1'b0, sv_q} + {1'b0, rv_q} - {1'b0, x_fire};
    assign issue    = run & (fetch_q != IN_N) & (occ < 2'd2);
    assign to_skid  = rv_q & ~(out_load & ~sv_q);

    always_comb begin
        xv_d = out_load ? (sv_q | rv_q) : 1'b1;
        xd_d = !out_load ? xd_q : sv_q ? sd_q : rv_q ? op_rd : xd_q;
        sv_d = (sv_q & ~out_load) | to_skid;
        sd_d = to_skid ? op_rd : sd_q;
    end

`ifdef MM_SRC_TLAST_CHECK_EN
    assign tl_bad = y_fire & (y_TLAST != (rx_cnt_q == OUT_N - 1'b1));
`else
    logic unused_tlast;
    assign unused_tlast = y_TLAST;
    assign tl_bad       = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            tx_cnt_q <= '0;
            fetch_q  <= '0;
            rx_cnt_q <= '0;
            rv_q     <= 1'b0;
            xv_q     <= 1'b0;
            sv_q     <= 1'b0;
            xd_q     <= '0;
            sd_q     <= '0;
            err_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    state_q  <= RUN;
                    tx_cnt_q <= '0;
                    fetch_q  <= '0;
                    rx_cnt_q <= '0;
                    rv_q     <= 1'b0;
                    xv_q     <= 1'b0;
                    sv_q     <= 1'b0;
                    err_q    <= 1'b0;
                end
                RUN: begin
                    if (tx_cnt_q == IN_N && rx_cnt_q == OUT_N) state_q <= DONE;
                    rv_q <= issue;
                    xv_q <= xv_d;
                    xd_q <= xd_d;
                    sv_q <= sv_d;
                    sd_q <= sd_d;
                    if (issue) fetch_q <= fetch_q + 1'b1;
                    if (x_fire) tx_cnt_q <= tx_cnt_q + 1'b1;
                    if (y_fire) rx_cnt_q <= rx_cnt_q + 1'b1;
                    if (tl_bad) err_q <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign x_TVALID = xv_q;
    assign x_TDATA  = xd_q;
    assign x_TLAST  = xv_q & (tx_cnt_q == IN_N - 1'b1);
    assign busy     = run;
    assign done     = state_q == DONE;
    assign err      = err_q;

    mm_sdp_ram #(.DEPTH(IN_WORDS), .WIDTH(AXIS_W)) u_op_ram (
        .clk     (clk),
        .we_i    (ld_en & (state_q == IDLE)),
        .waddr_i (ld_addr),
        .wdata_i (ld_data),
        .raddr_i (fetch_q[IAW-1:0]),
        .rdata_o (op_rd)
    );

    // Write is gated by rst so an aborted job leaves the buffer untouched on the reset edge.
    mm_sdp_ram #(.DEPTH(OUT_WORDS), .WIDTH(AXIS_W)) u_res_ram (
        .clk     (clk),
        .we_i    (y_fire & ~rst),
        .waddr_i (rx_cnt_q[OAW-1:0]),
        .wdata_i (y_TDATA),
        .raddr_i (rd_addr),
        .rdata_o (rd_data)
    );
endmodule

// File: tb/tb_mm_stream_src.sv
// tb_mm_stream_src: randomized self-checking bench for mm_stream_src against an in-order word model.
module tb_mm_stream_src;
    localparam int IN_WORDS  = 128;
    localparam int OUT_WORDS = 128;
    localparam int IAW = $clog2(IN_WORDS);
    localparam int OAW = $clog2(OUT_WORDS);

    logic clk = 1'b0, rst = 1'b1;
    logic ld_en = 1'b0, start = 1'b0;
    logic [IAW-1:0] ld_addr = '0;
    logic [31:0] ld_data = '0;
    logic [OAW-1:0] rd_addr = '0;
    logic [31:0] rd_data;
    logic busy, done, err;
    logic [31:0] x_TDATA;
    logic x_TVALID, x_TLAST, x_TREADY = 1'b0;
    logic [31:0] y_TDATA = '0;
    logic y_TVALID = 1'b0, y_TLAST = 1'b0, y_TREADY;

    logic [31:0] op_m [IN_WORDS];
    logic [31:0] res_m [OUT_WORDS];
    bit err_m = 1'b0;
    int n_chk = 0, n_err = 0;

    mm_stream_src #(.IN_WORDS(IN_WORDS), .OUT_WORDS(OUT_WORDS)) dut (
        .clk(clk), .rst(rst), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .rd_addr(rd_addr), .rd_data(rd_data), .start(start), .busy(busy), .done(done), .err(err),
        .x_TDATA(x_TDATA), .x_TVALID(x_TVALID), .x_TREADY(x_TREADY), .x_TLAST(x_TLAST),
        .y_TDATA(y_TDATA), .y_TVALID(y_TVALID), .y_TREADY(y_TREADY), .y_TLAST(y_TLAST)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic load_ops(input bit rnd);
        for (int i = 0; i < IN_WORDS; i++) begin
            @(negedge clk);
            ld_en   = 1'b1;
            ld_addr = IAW'(i);
            ld_data = rnd ? $urandom : 32'(i);
            op_m[i] = ld_data;
        end
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic readback();
        for (int a = 0; a < OUT_WORDS; a++) begin
            @(negedge clk);
            rd_addr = OAW'(a);
            @(negedge clk);
            chk("rd_data", rd_data, res_m[a]);
        end
    endtask

    // rmode: 0 ready always, 1 pattern 1,0,0,1, 2 random. ymode: 0 idle until tx done, 1 always valid, 2 random.
    task automatic run_job(input int rmode, input int ymode, input int bad, input int rst_at);
        int tx = 0, rx = 0, hold = 0, fin = 0;
        bit stall = 1'b0, hl = 1'b0, yact;
        logic [31:0] hd = '0;
        @(negedge clk);
        start = 1'b1;
        err_m = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            start   = 1'(cyc == 20);
            ld_en   = 1'(cyc == 20);
            ld_addr = IAW'(IN_WORDS - 1);
            ld_data = 32'hdead_beef;
            if (fin == 2) begin
                chk("done_pulse", 32'(done), 32'd1);
                chk("busy_in_done", 32'(busy), 32'd0);
                chk("err_end", 32'(err), 32'(err_m));
                start = 1'b0;
                ld_en = 1'b0;
                @(negedge clk);
                chk("done_low", 32'(done), 32'd0);
                return;
            end
            chk("busy", 32'(busy), 32'd1);
            chk("done_run", 32'(done), 32'd0);
            chk("err", 32'(err), 32'(err_m));
            if (cyc == 2) chk("x_latency", 32'(x_TVALID), 32'd1);
            if (stall) begin
                chk("stall_valid", 32'(x_TVALID), 32'd1);
                chk("stall_data", x_TDATA, hd);
                chk("stall_last", 32'(x_TLAST), 32'(hl));
            end
            if (tx == IN_WORDS) chk("x_valid_end", 32'(x_TVALID), 32'd0);
            else begin
                if (rmode == 0 && cyc >= 2) chk("x_no_bubble", 32'(x_TVALID), 32'd1);
                if (x_TVALID) begin
                    chk("x_data", x_TDATA, op_m[tx]);
                    chk("x_last", 32'(x_TLAST), 32'(tx == IN_WORDS - 1));
                end
            end
            chk("y_ready", 32'(y_TREADY), 32'(rx < OUT_WORDS));
            if (rst_at >= 0 && tx == rst_at) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                start = 1'b0;
                ld_en = 1'b0;
                chk("rst_x_valid", 32'(x_TVALID), 32'd0);
                chk("rst_y_ready", 32'(y_TREADY), 32'd0);
                chk("rst_busy", 32'(busy), 32'd0);
                x_TREADY = 1'b0;
                y_TVALID = 1'b0;
                return;
            end
            if (fin == 1) begin
                x_TREADY = 1'b0;
                y_TVALID = 1'b0;
                fin = 2;
                continue;
            end
            x_TREADY = rmode == 0 ? 1'b1 : rmode == 1 ? 1'(cyc % 4 == 0 || cyc % 4 == 3) : 1'($urandom_range(0, 1));
            if (ymode == 0 && tx == IN_WORDS) hold++;
            yact = ymode == 1 || (ymode == 2 && $urandom_range(0, 1) == 1) || (ymode == 0 && hold > 10);
            y_TVALID = yact;
            y_TDATA  = ymode == 2 ? $urandom : 32'hA000 + 32'(rx);
            y_TLAST  = (rx == OUT_WORDS - 1) != (rx == bad);
            if (x_TVALID && x_TREADY) tx++;
            if (y_TVALID && y_TREADY) begin
                res_m[rx] = y_TDATA;
`ifdef MM_SRC_TLAST_CHECK_EN
                if (y_TLAST != (rx == OUT_WORDS - 1)) err_m = 1'b1;
`endif
                rx++;
            end
            stall = x_TVALID && !x_TREADY;
            hd = x_TDATA;
            hl = x_TLAST;
            if (tx == IN_WORDS && rx == OUT_WORDS) fin = 1;
        end
        chk("job_timeout", 32'(tx), 32'(IN_WORDS));
        start = 1'b0;
        ld_en = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_state_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_xv", 32'(x_TVALID), 32'd0);
        chk("rst_xl", 32'(x_TLAST), 32'd0);
        chk("rst_xd", x_TDATA, 32'd0);
        chk("rst_yr", 32'(y_TREADY), 32'd0);
        rst = 1'b0;
        load_ops(1'b0);
        run_job(0, 0, -1, -1);
        readback();
        load_ops(1'b0);
        run_job(1, 1, -1, -1);
        readback();
        run_job(2, 1, 10, -1);
        run_job(0, 1, -1, -1);
        run_job(0, 1, -1, 40);
        run_job(0, 1, -1, -1);
        readback();
        load_ops(1'b1);
        for (int j = 0; j < 3; j++) begin
            run_job(2, 2, int'($urandom_range(0, OUT_WORDS - 1)), -1);
            readback();
        end
        run_job(2, 2, -1, int'($urandom_range(5, 100)));
        readback();
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
